// File: rtl/meter_timer_pkg.sv
// rtl/meter_timer_pkg.sv - shared state type, default timing constants and BCD helper for meter_timer
package meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_CLK_DIV = 100000000;
  localparam int DEF_SEG_LEN = 30;

  // Values never exceed 99, so one tens digit and one ones digit suffice.
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [7:0] tens;
    tens = v / 8'd10;
    return {tens[3:0], 4'(v - tens * 8'd10)};
  endfunction

endpackage

// File: rtl/meter_timer_if.sv
// rtl/meter_timer_if.sv - controller/timer signal bundle; BCD digits present with METER_TIMER_BCD_EN
interface meter_timer_if;

  logic       ct;
  logic       t;
  logic       busy;
  logic [7:0] secs_left;
`ifdef METER_TIMER_BCD_EN
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;

  modport master (output ct, input t, busy, secs_left, secs_tens, secs_ones);
  modport slave  (input ct, output t, busy, secs_left, secs_tens, secs_ones);
`else
  modport master (output ct, input t, busy, secs_left);
  modport slave  (input ct, output t, busy, secs_left);
`endif

endinterface

// File: rtl/meter_timer_tick_gen.sv
// rtl/meter_timer_tick_gen.sv - prescaler producing a one-cycle tick every CLK_DIV cycles
module tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/meter_timer.sv
// rtl/meter_timer.sv - segment timer: ct loads SEG_LEN seconds, t pulses once on expiry
// Optional METER_TIMER_BCD_EN adds registered BCD digits of secs_left.
module meter_timer
  import meter_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int SEG_LEN = DEF_SEG_LEN
) (
  input  logic          clk,
  input  logic          rst,
  meter_timer_if.slave  bus
);

  localparam logic [7:0] SEG = 8'(SEG_LEN);

  state_e     state_q, state_d;
  logic [7:0] secs_q, secs_d;
  logic       tick;
  logic       clear;

  // Prescaler is held at zero outside RUN and restarted by every ct.
  assign clear = (state_q != RUN) || bus.ct;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    case (state_q)
      IDLE: begin
        if (bus.ct) begin
          state_d = RUN;
          secs_d  = SEG;
        end
      end
      RUN: begin
        if (bus.ct) begin
          secs_d = SEG;
        end else if (tick) begin
          if (secs_q <= 8'd1) begin
            state_d = DONE;
            secs_d  = 8'd0;
          end else begin
            secs_d = secs_q - 8'd1;
          end
        end
      end
      DONE: begin
        if (bus.ct) begin
          state_d = RUN;
          secs_d  = SEG;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      secs_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
    end
  end

  assign bus.t         = (state_q == DONE);
  assign bus.busy      = (state_q == RUN);
  assign bus.secs_left = secs_q;

`ifdef METER_TIMER_BCD_EN
  logic [7:0] bcd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcd_q <= 8'd0;
    else     bcd_q <= to_bcd(secs_d);
  end

  assign bus.secs_tens = bcd_q[7:4];
  assign bus.secs_ones = bcd_q[3:0];
`endif

endmodule

// File: tb/tb_meter_timer.sv
// tb/tb_meter_timer.sv - randomized bench for meter_timer against a deadline-based reference model
module tb_meter_timer;

  localparam int DIV = 4;
  localparam int SEG = 3;

  logic clk = 1'b0;
  logic rst;

  meter_timer_if bus ();

  meter_timer #(.CLK_DIV(DIV), .SEG_LEN(SEG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a segment is just a start cycle and a fixed deadline.
  int cyc     = 0;
  int start   = 0;
  bit running = 1'b0;
  bit t_m     = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    int exp_secs;
    exp_secs = running ? SEG - (cyc - start) / DIV : 0;
    chk("t", int'(bus.t), int'(t_m));
    chk("busy", int'(bus.busy), int'(running));
    chk("secs_left", int'(bus.secs_left), exp_secs);
`ifdef METER_TIMER_BCD_EN
    chk("secs_tens", int'(bus.secs_tens), exp_secs / 10);
    chk("secs_ones", int'(bus.secs_ones), exp_secs % 10);
`endif
  endtask

  task automatic step(input logic ct_v);
    bus.ct = ct_v;
    @(posedge clk);
    cyc++;
    if (rst) begin
      running = 1'b0;
      t_m     = 1'b0;
    end else if (ct_v) begin
      running = 1'b1;
      start   = cyc;
      t_m     = 1'b0;
    end else if (running && (cyc - start == SEG * DIV)) begin
      running = 1'b0;
      t_m     = 1'b1;
    end else begin
      t_m = 1'b0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    running = 1'b0;
    t_m     = 1'b0;
    check_outputs();
    step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int burst;
    int r;
    rst    = 1'b1;
    bus.ct = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Single segment, then expiry and return to idle.
    step(1'b1);
    repeat (16) step(1'b0);

    // Restart mid-segment abandons the first deadline.
    step(1'b1);
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (15) step(1'b0);

    // ct in the DONE cycle chains a second segment.
    step(1'b1);
    repeat (SEG * DIV - 1) step(1'b0);
    step(1'b0);
    step(1'b1);
    repeat (SEG * DIV + 3) step(1'b0);

    // Asynchronous reset mid-segment, then a fresh segment.
    step(1'b1);
    repeat (5) step(1'b0);
    async_reset();
    repeat (15) step(1'b0);
    step(1'b1);
    repeat (SEG * DIV + 2) step(1'b0);

    // Held ct acts as repeated restarts.
    repeat (4) step(1'b1);
    repeat (SEG * DIV + 2) step(1'b0);

    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      if (burst > 0) begin
        burst--;
        step(1'b1);
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 4) begin
          step(1'b1);
        end else if (r < 6) begin
          burst = int'($urandom_range(1, 4));
          step(1'b1);
        end else if (r == 99) begin
          async_reset();
        end else begin
          step(1'b0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
